id_ex_control_stage: RTL and testbench
======================================

// Module: id_ex_control_stage
// PURPOSE
//  ID->EX pipeline stage for the 32-bit packed control bundle produced by decode.
//  Registers the control word and drives the control_in bus consumed by execute.
//  Provides a 2-entry skid buffer with valid/ready flow control, a pipeline flush
//  and a saturating count of execute-starved cycles.
// PARAMETERS
//  CTRL_W       32          width of packed control word
//  NOP_CONTROL  32'h0000_0000  control word driven when no valid entry (harmless bubble)
//  CNT_W        16          width of starvation counter
// PORTS
//  clk            in   1       pipeline clock
//  rst_n          in   1       asynchronous active-low reset
//  dec_valid      in   1       decode presents a control word
//  dec_ready      out  1       stage can accept a word this cycle
//  dec_control    in   CTRL_W  control word from decode
//  flush          in   1       discard all held words (branch/exception redirect)
//  ex_valid       out  1       control_in holds a valid word
//  ex_ready       in   1       execute consumes control_in this cycle
//  control_in     out  CTRL_W  control word to execute
//  stall_cnt      out  CNT_W   cycles with ex_ready=1 and ex_valid=0, saturating
//  clr_stats      in   1       synchronous clear of stall_cnt
// BEHAVIOUR
//  - Clock clk; reset rst_n asynchronous, active-low. Reset values: ex_valid=0,
//    control_in=NOP_CONTROL, dec_ready=1, stall_cnt=0, state=EMPTY, skid reg=NOP_CONTROL.
//  - All outputs registered; no combinational path dec_* -> ex_* or ex_ready -> dec_ready.
//  - Handshakes: accept = dec_valid & dec_ready; consume = ex_valid & ex_ready.
//    Words leave in arrival order; none duplicated or dropped except by flush.
//  - State machine (main = control_in register, skid = overflow register):
//    EMPTY: accept -> FULL, word loaded into main (latency 1 cycle to control_in).
//    FULL : accept & !consume -> SKID (word into skid, dec_ready drops next cycle);
//           accept & consume  -> FULL (new word into main);
//           !accept & consume -> EMPTY; else hold.
//    SKID : consume -> FULL (skid moves to main, skid=NOP_CONTROL); else hold.
//           dec_ready=0 in SKID; dec_ready=1 in EMPTY and FULL.
//  - ex_valid=1 in FULL and SKID. When ex_valid=0, control_in = NOP_CONTROL.
//  - control_in and ex_valid stable while ex_valid & !ex_ready.
//  - flush: highest priority. Next cycle state=EMPTY, ex_valid=0,
//    control_in=NOP_CONTROL, dec_ready=1. A word offered with dec_valid in the
//    flush cycle is dropped, even if dec_ready=1; a consume in the flush cycle
//    still counts as a transfer to execute.
//  - stall_cnt: +1 per cycle with ex_ready & !ex_valid; holds at 2^CNT_W-1.
//    clr_stats sets 0 next cycle (clear wins over increment). flush does not clear it.
//  - Reset asserted mid-operation: all held words discarded immediately
//    (asynchronous), outputs take reset values; first accept allowed on the first
//    rising edge after rst_n deasserts.
// TESTING
//  1 Single word: dec_control=32'hA5A5_0001 accepted, ex_ready=1 -> ex_valid=1 with
//    control_in=32'hA5A5_0001 exactly 1 cycle later, then EMPTY, control_in=0.
//  2 Backpressure: ex_ready=0, send 32'h11, 32'h22, 32'h33 -> dec_ready=0 after 2nd;
//    3rd held by decode; release ex_ready -> out 32'h11, 32'h22, 32'h33 in order.
//  3 Streaming: dec_valid=ex_ready=1 for 100 cycles, incrementing words ->
//    one word per cycle, dec_ready never drops, stall_cnt stays 0 after the first
//    fill cycle.
//  4 Flush in SKID with dec_valid=1, dec_control=32'h44 -> next cycle ex_valid=0,
//    control_in=NOP_CONTROL, 32'h44 never appears on control_in.
//  5 Starvation: ex_ready=1, dec_valid=0 for 70000 cycles with CNT_W=16 ->
//    stall_cnt=16'hFFFF held; clr_stats together with ex_ready=1 -> stall_cnt=0.
//  6 rst_n pulsed low between clock edges while in SKID -> outputs reach reset
//    values before the next edge; a subsequent word passes normally.

Source files
------------

// File: rtl/id_ex_control_stage.sv
// rtl/id_ex_control_stage.sv - ID->EX control-word stage with 2-entry skid buffer, flush and starvation counter
module id_ex_control_stage #(
    parameter int                 CTRL_W      = 32,
    parameter logic [CTRL_W-1:0]  NOP_CONTROL = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [CTRL_W-1:0] dec_control,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [CTRL_W-1:0] control_in,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_stats
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_q, main_d;
    logic [CTRL_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept;
    logic              consume;

    // Outputs decode only flop state, so nothing from dec_* or ex_ready reaches them combinationally.
    assign ex_valid   = (state_q != EMPTY);
    assign dec_ready  = (state_q != SKID);
    assign control_in = main_q;
    assign stall_cnt  = stall_cnt_q;

    assign accept  = dec_valid & dec_ready;
    assign consume = ex_valid & ex_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_CONTROL;
            skid_d  = NOP_CONTROL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_d  = dec_control;
                    end
                end
                FULL: begin
                    if (accept && !consume) begin
                        state_d = SKID;
                        skid_d  = dec_control;
                    end else if (accept && consume) begin
                        main_d  = dec_control;
                    end else if (consume) begin
                        state_d = EMPTY;
                        main_d  = NOP_CONTROL;
                    end
                end
                SKID: begin
                    if (consume) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_CONTROL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_CONTROL;
                    skid_d  = NOP_CONTROL;
                end
            endcase
        end
    end

    // Clear beats increment; counter sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stats) begin
            stall_cnt_d = '0;
        end else if (ex_ready && !ex_valid && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= NOP_CONTROL;
            skid_q      <= NOP_CONTROL;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_control_stage.sv
// tb/tb_id_ex_control_stage.sv - directed vector bench for id_ex_control_stage
module tb_id_ex_control_stage;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_control;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] control_in;
    logic [15:0] stall_cnt;
    logic        clr_stats;

    int checks;
    int failures;

    id_ex_control_stage #(
        .CTRL_W     (32),
        .NOP_CONTROL(32'h0000_0000),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_control(dec_control),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .control_in (control_in),
        .stall_cnt  (stall_cnt),
        .clr_stats  (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [31:0] dc;
        logic        fl;
        logic        er;
        logic        clr;
        logic        ev;
        logic [31:0] ci;
        logic        dr;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [31:0] dc, input logic fl,
                         input logic er, input logic clr);
        dec_valid   = dv;
        dec_control = dc;
        flush       = fl;
        ex_ready    = er;
        clr_stats   = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [31:0] ci,
                            input logic dr, input logic [15:0] sc);
        chk({tag, ".ex_valid"},   {31'd0, ex_valid},  {31'd0, ev});
        chk({tag, ".control_in"}, control_in,         ci);
        chk({tag, ".dec_ready"},  {31'd0, dec_ready}, {31'd0, dr});
        chk({tag, ".stall_cnt"},  {16'd0, stall_cnt}, {16'd0, sc});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //                dv    dc            fl    er    clr   ev    ci            dr    sc
        vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 16'd1};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 16'd1};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 16'd0};
        vecs[3]  = '{1'b1, 32'h11,        1'b0, 1'b0, 1'b0, 1'b1, 32'h11,        1'b1, 16'd0};
        vecs[4]  = '{1'b1, 32'h22,        1'b0, 1'b0, 1'b0, 1'b1, 32'h11,        1'b0, 16'd0};
        vecs[5]  = '{1'b1, 32'h33,        1'b0, 1'b0, 1'b0, 1'b1, 32'h11,        1'b0, 16'd0};
        vecs[6]  = '{1'b1, 32'h33,        1'b0, 1'b1, 1'b0, 1'b1, 32'h22,        1'b1, 16'd0};
        vecs[7]  = '{1'b1, 32'h33,        1'b0, 1'b1, 1'b0, 1'b1, 32'h33,        1'b1, 16'd0};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 16'd0};
        vecs[9]  = '{1'b1, 32'h55,        1'b0, 1'b0, 1'b0, 1'b1, 32'h55,        1'b1, 16'd0};
        vecs[10] = '{1'b1, 32'h66,        1'b0, 1'b0, 1'b0, 1'b1, 32'h55,        1'b0, 16'd0};
        vecs[11] = '{1'b1, 32'h44,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 16'd0};
        vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 16'd0};
        vecs[13] = '{1'b1, 32'h77,        1'b0, 1'b0, 1'b0, 1'b1, 32'h77,        1'b1, 16'd0};
        vecs[14] = '{1'b1, 32'h88,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 16'd0};
        vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 16'd1};
        vecs[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 16'd0};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_outs("reset", 1'b0, 32'h0, 1'b1, 16'd0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].dv, vecs[i].dc, vecs[i].fl, vecs[i].er, vecs[i].clr);
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ci, vecs[i].dr, vecs[i].sc);
        end

        // Streaming: one word per cycle, stall counter cleared on the fill cycle.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h1000 + i, 1'b0, 1'b1, (i == 0));
            step();
            chk_outs($sformatf("stream%0d", i), 1'b1, 32'h1000 + i, 1'b1, 16'd0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        chk_outs("stream_drain", 1'b0, 32'h0, 1'b1, 16'd0);

        // Starvation: count up to saturation and hold; clear wins over increment.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step();
        chk("starve_clr0", {16'd0, stall_cnt}, 32'd0);
        clr_stats = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            step();
            if (i == 65534) chk("starve_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
            if (i == 65535) chk("starve_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
        end
        chk("starve_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        clr_stats = 1'b1;
        step();
        chk("starve_clr", {16'd0, stall_cnt}, 32'd0);

        // Asynchronous reset while in SKID, then a fresh word passes.
        drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
        step();
        dec_control = 32'hBB;
        step();
        chk_outs("pre_rst", 1'b1, 32'hAA, 1'b0, 16'd0);
        rst_n = 1'b0;
        #2;
        chk_outs("async_rst", 1'b0, 32'h0, 1'b1, 16'd0);
        rst_n = 1'b1;
        drive(1'b1, 32'hCC, 1'b0, 1'b1, 1'b0);
        step();
        chk("post_rst_ev", {31'd0, ex_valid}, 32'd1);
        chk("post_rst_ci", control_in, 32'hCC);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        chk("post_rst_empty_ev", {31'd0, ex_valid}, 32'd0);
        chk("post_rst_empty_ci", control_in, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
